// File: rtl/unique0_csr_pkg.sv
// rtl/unique0_csr_pkg.sv - shared types and CSR address map for unique0_csr
package unique0_csr_pkg;

  typedef enum logic [3:0] {
    IALIGN   = 4'd0,
    IFAULT   = 4'd1,
    IILLEGAL = 4'd2,
    EBREAK   = 4'd3,
    LALIGN   = 4'd4,
    LFAULT   = 4'd5,
    SALIGN   = 4'd6,
    SFAULT   = 4'd7,
    UCALL    = 4'd8,
    SCALL    = 4'd9,
    ERET     = 4'd10,
    MCALL    = 4'd11,
    IPFAULT  = 4'd12,
    LPFAULT  = 4'd13,
    SPFAULT  = 4'd15
  } ecause_t;

  localparam logic [11:0] CSR_SATP      = 12'h180;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

endpackage

// File: rtl/unique0_csr.sv
// rtl/unique0_csr.sv - machine-mode CSR file with trap capture and fetch redirect
module unique0_csr
  import unique0_csr_pkg::*;
(
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic [11:0] mem1_csr_addr,
  input  logic [1:0]  mem1_csr_write,
  input  logic [31:0] mem1_csr_din,
  output logic        csr_error,
  output logic        csr_flush,
  output logic [31:0] csr_dout,
  input  logic        wb_valid,
  input  logic        wb_stall,
  input  logic        wb_exc,
  input  ecause_t     wb_exc_cause,
  input  logic        wb_flush,
  input  logic [31:2] wb_pc,
  input  logic [31:0] wb_data,
  output logic        csr_kill,
  output logic        csr_fe_inhibit,
  output logic        csr_setpc,
  output logic [31:2] csr_newpc,
  output logic [31:0] csr_satp
);

  logic [31:0] satp;
  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:2] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] cycle;
  logic [63:0] instret;

  logic        wen;
  logic        hit;
  logic [31:0] wdata;
  logic        trap;
  logic        eret;
  logic [31:0] tval;
  logic [31:0] mcause_wdata;

  assign wen  = (mem1_csr_write != OP_READ);
  assign trap = wb_exc && (wb_exc_cause != ERET);
  assign eret = wb_exc && (wb_exc_cause == ERET);

  always_comb begin
    hit      = 1'b1;
    csr_dout = 32'h0;
    case (mem1_csr_addr)
      CSR_SATP:                csr_dout = satp;
      CSR_MSTATUS:             csr_dout = {19'h0, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};
      CSR_MTVEC:               csr_dout = mtvec;
      CSR_MSCRATCH:            csr_dout = mscratch;
      CSR_MEPC:                csr_dout = {mepc, 2'b00};
      CSR_MCAUSE:              csr_dout = mcause;
      CSR_MTVAL:               csr_dout = mtval;
      CSR_CYCLE, CSR_TIME:     csr_dout = cycle[31:0];
      CSR_INSTRET:             csr_dout = instret[31:0];
      CSR_CYCLEH, CSR_TIMEH:   csr_dout = cycle[63:32];
      CSR_INSTRETH:            csr_dout = instret[63:32];
      default:                 hit      = 1'b0;
    endcase
  end

  always_comb begin
    wdata = mem1_csr_din;
    case (mem1_csr_write)
      OP_SET:   wdata = csr_dout | mem1_csr_din;
      OP_CLEAR: wdata = csr_dout & ~mem1_csr_din;
      default:  wdata = mem1_csr_din;
    endcase
  end

  // Interrupt causes keep a 5-bit code, exceptions only 4 bits.
  assign mcause_wdata = wdata[31] ? {1'b1, 26'h0, wdata[4:0]} : {28'h0, wdata[3:0]};

  always_comb begin
    tval = 32'h0;
    case (wb_exc_cause)
      IALIGN, IFAULT, IPFAULT, EBREAK:                    tval = {wb_pc, 2'b00};
      IILLEGAL, LALIGN, LFAULT, SALIGN, SFAULT,
      LPFAULT, SPFAULT:                                   tval = wb_data;
      default:                                            tval = 32'h0;
    endcase
  end

  assign csr_error      = ~hit | (wen & (mem1_csr_addr[11:10] == 2'b11));
  assign csr_flush      = wen & (mem1_csr_addr == CSR_SATP);
  assign csr_kill       = wb_exc | (wb_valid & wb_flush);
  assign csr_fe_inhibit = wb_stall;
  assign csr_setpc      = wb_exc | wb_stall;
  assign csr_newpc      = trap ? mtvec[31:2] : (eret ? mepc : wb_pc);
  assign csr_satp       = satp;

  // Trap/ERET updates go first so a same-cycle CSR write to that register wins.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      satp     <= 32'h0;
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= 32'h0;
      mscratch <= 32'h0;
      mepc     <= 30'h0;
      mcause   <= 32'h0;
      mtval    <= 32'h0;
      cycle    <= 64'h0;
      instret  <= 64'h0;
    end else begin
      cycle <= cycle + 64'd1;
      if (wb_valid) instret <= instret + 64'd1;
      if (trap) begin
        mpie   <= mie;
        mie    <= 1'b0;
        mepc   <= wb_pc;
        mcause <= {28'h0, wb_exc_cause};
        mtval  <= tval;
      end else if (eret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end
      if (wen) begin
        case (mem1_csr_addr)
          CSR_SATP:     satp     <= wdata;
          CSR_MSTATUS: begin
            mie  <= wdata[3];
            mpie <= wdata[7];
          end
          CSR_MTVEC:    mtvec    <= {wdata[31:2], 1'b0, wdata[0]};
          CSR_MSCRATCH: mscratch <= wdata;
          CSR_MEPC:     mepc     <= wdata[31:2];
          CSR_MCAUSE:   mcause   <= mcause_wdata;
          CSR_MTVAL:    mtval    <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unique0_csr.sv
// tb/tb_unique0_csr.sv - directed self-checking bench for unique0_csr
module tb_unique0_csr;
  import unique0_csr_pkg::*;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic [11:0] mem1_csr_addr;
  logic [1:0]  mem1_csr_write;
  logic [31:0] mem1_csr_din;
  logic        csr_error;
  logic        csr_flush;
  logic [31:0] csr_dout;
  logic        wb_valid;
  logic        wb_stall;
  logic        wb_exc;
  ecause_t     wb_exc_cause;
  logic        wb_flush;
  logic [31:2] wb_pc;
  logic [31:0] wb_data;
  logic        csr_kill;
  logic        csr_fe_inhibit;
  logic        csr_setpc;
  logic [31:2] csr_newpc;
  logic [31:0] csr_satp;

  int tests  = 0;
  int failed = 0;
  logic [31:0] c0, i0;

  unique0_csr dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .mem1_csr_addr(mem1_csr_addr), .mem1_csr_write(mem1_csr_write), .mem1_csr_din(mem1_csr_din),
    .csr_error(csr_error), .csr_flush(csr_flush), .csr_dout(csr_dout),
    .wb_valid(wb_valid), .wb_stall(wb_stall), .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
    .wb_flush(wb_flush), .wb_pc(wb_pc), .wb_data(wb_data),
    .csr_kill(csr_kill), .csr_fe_inhibit(csr_fe_inhibit), .csr_setpc(csr_setpc),
    .csr_newpc(csr_newpc), .csr_satp(csr_satp)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one CSR request just after a falling edge with writeback idle.
  task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    @(negedge clk_core);
    mem1_csr_addr  = a;
    mem1_csr_write = op;
    mem1_csr_din   = d;
    wb_valid = 1'b0; wb_stall = 1'b0; wb_exc = 1'b0; wb_flush = 1'b0;
    wb_exc_cause = IALIGN; wb_pc = 30'h0; wb_data = 32'h0;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    mem1_csr_addr = 12'h0; mem1_csr_write = OP_READ; mem1_csr_din = 32'h0;
    wb_valid = 1'b0; wb_stall = 1'b0; wb_exc = 1'b0; wb_flush = 1'b0;
    wb_exc_cause = IALIGN; wb_pc = 30'h0; wb_data = 32'h0;
    repeat (3) @(negedge clk_core);
    reset_n = 1'b1;
    mem1_csr_addr = CSR_CYCLE; #1;
    check("rst_cycle", csr_dout, 32'h0);
    mem1_csr_addr = CSR_CYCLEH; #1;
    check("rst_cycleh", csr_dout, 32'h0);
    check("rst_satp_port", csr_satp, 32'h0);

    step(CSR_MSTATUS, OP_READ, 0);  check("rst_mstatus", csr_dout, 32'h0000_1800);
    step(CSR_MTVEC, OP_READ, 0);    check("rst_mtvec", csr_dout, 32'h0);
    step(CSR_MSCRATCH, OP_READ, 0); check("rst_mscratch", csr_dout, 32'h0);
    step(CSR_MEPC, OP_READ, 0);     check("rst_mepc", csr_dout, 32'h0);
    step(CSR_MCAUSE, OP_READ, 0);   check("rst_mcause", csr_dout, 32'h0);
    step(CSR_MTVAL, OP_READ, 0);    check("rst_mtval", csr_dout, 32'h0);
    check("rst_err_ok", {31'h0, csr_error}, 32'h0);
    step(CSR_INSTRET, OP_READ, 0);  check("rst_instret", csr_dout, 32'h0);

    step(12'h7C0, OP_READ, 0);
    check("unimpl_err", {31'h0, csr_error}, 32'h1);
    check("unimpl_dout", csr_dout, 32'h0);

    step(CSR_MSCRATCH, OP_WRITE, 32'hA5A5_0F0F);
    check("mscr_wr_err", {31'h0, csr_error}, 32'h0);
    check("mscr_wr_flush", {31'h0, csr_flush}, 32'h0);
    step(CSR_MSCRATCH, OP_SET, 32'h0000_00F0);
    check("mscr_pre_set", csr_dout, 32'hA5A5_0F0F);
    step(CSR_MSCRATCH, OP_CLEAR, 32'h0000_000F);
    check("mscr_pre_clr", csr_dout, 32'hA5A5_0FFF);
    step(CSR_MSCRATCH, OP_READ, 0);
    check("mscr_final", csr_dout, 32'hA5A5_0FF0);

    step(CSR_SATP, OP_WRITE, 32'h8000_1234);
    check("satp_flush", {31'h0, csr_flush}, 32'h1);
    check("satp_port_pre", csr_satp, 32'h0);
    step(CSR_SATP, OP_READ, 0);
    check("satp_port", csr_satp, 32'h8000_1234);
    check("satp_noflush", {31'h0, csr_flush}, 32'h0);

    step(CSR_MTVEC, OP_WRITE, 32'h0000_0103);
    step(CSR_MTVEC, OP_READ, 0);    check("mtvec_bit1", csr_dout, 32'h0000_0101);
    step(CSR_MSTATUS, OP_WRITE, 32'h0000_0008);
    step(CSR_MSTATUS, OP_READ, 0);  check("mstatus_mie", csr_dout, 32'h0000_1808);

    step(CSR_MSCRATCH, OP_READ, 0);
    wb_exc = 1'b1; wb_exc_cause = IILLEGAL; wb_pc = 30'h10; wb_data = 32'hDEAD; #1;
    check("trap_newpc", {2'b0, csr_newpc}, 32'h40);
    check("trap_kill", {31'h0, csr_kill}, 32'h1);
    check("trap_setpc", {31'h0, csr_setpc}, 32'h1);
    step(CSR_MEPC, OP_READ, 0);     check("trap_mepc", csr_dout, 32'h40);
    step(CSR_MCAUSE, OP_READ, 0);   check("trap_mcause", csr_dout, 32'h2);
    step(CSR_MTVAL, OP_READ, 0);    check("trap_mtval", csr_dout, 32'hDEAD);
    step(CSR_MSTATUS, OP_READ, 0);  check("trap_mstatus", csr_dout, 32'h0000_1880);

    step(CSR_MSCRATCH, OP_READ, 0);
    wb_exc = 1'b1; wb_exc_cause = ERET; wb_pc = 30'h33; #1;
    check("eret_newpc", {2'b0, csr_newpc}, 32'h10);
    step(CSR_MSTATUS, OP_READ, 0);  check("eret_mstatus", csr_dout, 32'h0000_1888);
    step(CSR_MEPC, OP_READ, 0);     check("eret_mepc", csr_dout, 32'h40);
    step(CSR_MCAUSE, OP_READ, 0);   check("eret_mcause", csr_dout, 32'h2);

    step(CSR_MSCRATCH, OP_READ, 0);
    wb_exc = 1'b1; wb_exc_cause = EBREAK; wb_pc = 30'h20; wb_data = 32'h1111; #1;
    step(CSR_MTVAL, OP_READ, 0);    check("ebreak_mtval", csr_dout, 32'h80);

    step(CSR_MEPC, OP_WRITE, 32'h0000_1234);
    wb_exc = 1'b1; wb_exc_cause = MCALL; wb_pc = 30'h50; wb_data = 32'h2222; #1;
    step(CSR_MEPC, OP_READ, 0);     check("prio_mepc", csr_dout, 32'h1234);
    step(CSR_MCAUSE, OP_READ, 0);   check("mcall_mcause", csr_dout, 32'hB);
    step(CSR_MTVAL, OP_READ, 0);    check("mcall_mtval", csr_dout, 32'h0);

    step(CSR_MCAUSE, OP_WRITE, 32'h8000_001F);
    step(CSR_MCAUSE, OP_READ, 0);   check("mcause_irq", csr_dout, 32'h8000_001F);
    step(CSR_MCAUSE, OP_WRITE, 32'h0000_001F);
    step(CSR_MCAUSE, OP_READ, 0);   check("mcause_exc", csr_dout, 32'h0000_000F);

    step(CSR_CYCLE, OP_WRITE, 32'h5);
    check("ro_write_err", {31'h0, csr_error}, 32'h1);

    step(CSR_MSCRATCH, OP_READ, 0);
    wb_valid = 1'b1; wb_flush = 1'b1; wb_pc = 30'h77; #1;
    check("flush_kill", {31'h0, csr_kill}, 32'h1);
    check("flush_setpc", {31'h0, csr_setpc}, 32'h0);
    check("flush_newpc", {2'b0, csr_newpc}, 32'h77);
    step(CSR_MSCRATCH, OP_READ, 0);
    wb_stall = 1'b1; #1;
    check("stall_inhibit", {31'h0, csr_fe_inhibit}, 32'h1);
    check("stall_setpc", {31'h0, csr_setpc}, 32'h1);
    check("stall_kill", {31'h0, csr_kill}, 32'h0);

    step(CSR_CYCLE, OP_READ, 0);
    c0 = csr_dout;
    mem1_csr_addr = CSR_INSTRET; #1;
    i0 = csr_dout;
    for (int k = 0; k < 10; k++) begin
      wb_valid = (k < 4);
      @(negedge clk_core);
    end
    wb_valid = 1'b0;
    mem1_csr_addr = CSR_CYCLE; #1;
    check("cycle_delta", csr_dout, c0 + 32'd10);
    mem1_csr_addr = CSR_INSTRET; #1;
    check("instret_delta", csr_dout, i0 + 32'd4);
    mem1_csr_addr = CSR_INSTRETH; #1;
    check("instret_hi", csr_dout, 32'h0);

    step(CSR_MSTATUS, OP_WRITE, 32'h0);
    step(CSR_MSTATUS, OP_READ, 0);  check("mstatus_mpp", csr_dout, 32'h0000_1800);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
